// File: rtl/sr_bank_writer_pkg.sv
// Shared definitions for the SR bank write path: FSM state encoding and the
// per-bit SR command encoding also used by the SR storage bank.
package sr_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SETTLE = 2'd2,
    CHECK  = 2'd3
  } state_t;

  localparam logic [1:0] HOLD      = 2'b00;
  localparam logic [1:0] CLR       = 2'b01;
  localparam logic [1:0] SET       = 2'b10;
  localparam logic [1:0] FORBIDDEN = 2'b11;

  localparam int CNT_W = 4;

  // {s, r} command needed to move one bit from its current value to target.
  function automatic logic [1:0] sr_cmd(input logic target, input logic q);
    if (target == q) return HOLD;
    return target ? SET : CLR;
  endfunction

endpackage

// File: rtl/sr_bank_writer_if.sv
// Request handshake between a register-write master and sr_bank_writer.
interface sr_bank_writer_if #(
  parameter int WIDTH = 8
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_data;

  modport master (output req_valid, output req_data, input  req_ready);
  modport slave  (input  req_valid, input  req_data, output req_ready);
endinterface

// File: rtl/sr_bank_writer_excite_calc.sv
// Combinational excitation masks: set only bits that must rise, clear only
// bits that must fall; s and r are mutually exclusive per bit by construction.
module sr_excite_calc
  import sr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] set_mask,
  output logic [WIDTH-1:0] clr_mask
);

  // NOTE: every output of a combinational block gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    for (int i = 0; i < WIDTH; i++) begin
      {set_mask[i], clr_mask[i]} = sr_cmd(target[i], q[i]);
    end
  end

endmodule

// File: rtl/sr_bank_writer.sv
// Write-side driver for an SR flip-flop bank: pulses set/reset only on bits
// that differ, waits SETTLE_CYCLES, then reads back. Optional SR_RETRY_EN
// adds one re-drive attempt after a mismatching readback.
module sr_bank_writer
  import sr_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  sr_bank_writer_if.slave   bus,
  input  logic [WIDTH-1:0]  q_in,
  output logic [WIDTH-1:0]  s_out,
  output logic [WIDTH-1:0]  r_out,
  output logic              done,
  output logic              err,
  output logic [WIDTH-1:0]  err_mask
);

  localparam logic [CNT_W-1:0] SETTLE_INIT = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] calc_target, set_calc, clr_calc;
  logic             accept, mismatch, retry_go;

  assign accept   = bus.req_valid & bus.req_ready;
  assign mismatch = |(q_in ^ target);

  // In IDLE the masks are computed against the incoming word; on a retry they
  // are recomputed against the latched target and the bank's present state.
  assign calc_target = (state == IDLE) ? bus.req_data : target;

  sr_excite_calc #(.WIDTH(WIDTH)) u_calc (
    .target   (calc_target),
    .q        (q_in),
    .set_mask (set_calc),
    .clr_mask (clr_calc)
  );

`ifdef SR_RETRY_EN
  logic retry_used;

  assign retry_go = (state == CHECK) & mismatch & ~retry_used;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retry_used <= 1'b0;
    end else if (state == IDLE) begin
      retry_used <= 1'b0;
    end else if (retry_go) begin
      retry_used <= 1'b1;
    end
  end
`else
  assign retry_go = 1'b0;
`endif

  // NOTE: reset is asynchronous so an abort stops excitation immediately,
  // without waiting for a clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    done          = 1'b0;
    bus.req_ready = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = reset;
        if (accept) state_nxt = DRIVE;
      end
      DRIVE:  state_nxt = SETTLE;
      SETTLE: if (cnt == '0) state_nxt = CHECK;
      CHECK: begin
        done      = ~retry_go;
        state_nxt = retry_go ? DRIVE : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Excitation is registered so the bank sees clean, glitch-free pulses that
  // are high exactly for the DRIVE cycle. err/err_mask update at the end of
  // CHECK and hold until the next accepted request.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      target   <= '0;
      cnt      <= '0;
      s_out    <= '0;
      r_out    <= '0;
      err      <= 1'b0;
      err_mask <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            target   <= bus.req_data;
            s_out    <= set_calc;
            r_out    <= clr_calc;
            err      <= 1'b0;
            err_mask <= '0;
          end
        end
        DRIVE: begin
          s_out <= '0;
          r_out <= '0;
          cnt   <= SETTLE_INIT;
        end
        SETTLE: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        CHECK: begin
          if (retry_go) begin
            s_out <= set_calc;
            r_out <= clr_calc;
          end else begin
            err_mask <= q_in ^ target;
            err      <= mismatch;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sr_bank_writer.sv
// Self-checking bench for sr_bank_writer: behavioural SR bank with stuck-at-0
// injection, a vector table, a done-time scoreboard and hand-written corners.
module tb_sr_bank_writer;

  localparam int W      = 8;
  localparam int SETTLE = 2;
  localparam int LAT    = 2 + SETTLE;

  logic         clk   = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] q_in, s_out, r_out, err_mask;
  logic         done, err;

  always #5 clk = ~clk;

  sr_bank_writer_if #(.WIDTH(W)) bus ();

  sr_bank_writer #(.WIDTH(W), .SETTLE_CYCLES(SETTLE)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .q_in     (q_in),
    .s_out    (s_out),
    .r_out    (r_out),
    .done     (done),
    .err      (err),
    .err_mask (err_mask)
  );

  // Behavioural SR bank; stuck0 bits read back as 0 whatever is driven.
  logic [W-1:0] bank_q   = '0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] stuck0   = '0;
  logic         load_en  = 1'b1;

  always @(posedge clk) begin
    if (load_en) bank_q <= load_val;
    else         bank_q <= (bank_q | s_out) & ~r_out;
  end
  assign q_in = bank_q & ~stuck0;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) check("s_and_r_exclusive", 32'(s_out & r_out), 32'h0);

  typedef struct {
    logic [W-1:0] start_q, req, stuck, exp_s, exp_r, exp_mask;
    logic         exp_err;
  } vec_t;

  typedef struct {
    logic [W-1:0] s, r, mask, final_q;
    logic         err;
    int           lat;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[5];

  task automatic run_txn(input vec_t v);
    exp_t e;
    int   n;
    logic seen;
    @(negedge clk);
    load_en = 1'b1; load_val = v.start_q; stuck0 = v.stuck;
    @(negedge clk);
    load_en = 1'b0;
    check("idle_ready", bus.req_ready, 1);
    bus.req_data  = v.req;
    bus.req_valid = 1'b1;
    e.s = v.exp_s; e.r = v.exp_r; e.mask = v.exp_mask; e.err = v.exp_err;
    e.final_q = v.req & ~v.stuck;
    e.lat = LAT;
`ifdef SR_RETRY_EN
    if (v.exp_err) e.lat = 2 * LAT;
`endif
    @(posedge clk);
    sb.push_back(e);
    #1 bus.req_valid = 1'b0;
    n = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        check("drive_s", s_out, sb[0].s);
        check("drive_r", r_out, sb[0].r);
        check("err_cleared", err, 0);
      end
`ifdef SR_RETRY_EN
      if (v.exp_err && n == LAT + 1) begin
        check("retry_s", s_out, v.req & v.stuck);
        check("retry_r", r_out, 0);
      end
`endif
      if (done) seen = 1'b1;
    end
    e = sb.pop_front();
    check("done_seen", seen, 1);
    check("done_latency", n, e.lat);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("err", err, e.err);
    check("err_mask", err_mask, e.mask);
    check("bank_final", q_in, e.final_q);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    //           start  req    stuck  exp_s  exp_r  mask   err
    vecs[0] = '{8'h0F, 8'hF0, 8'h00, 8'hF0, 8'h0F, 8'h00, 1'b0};
    vecs[1] = '{8'hA5, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
    vecs[2] = '{8'h00, 8'hFF, 8'h08, 8'hFF, 8'h00, 8'h08, 1'b1};
    vecs[3] = '{8'h55, 8'hAA, 8'h00, 8'hAA, 8'h55, 8'h00, 1'b0};
    vecs[4] = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 1'b0};

    // Reset held with a pending request: nothing may be accepted or driven.
    bus.req_valid = 1'b1;
    bus.req_data  = 8'hAA;
    repeat (3) begin
      @(negedge clk);
      check("rst_ready", bus.req_ready, 0);
      check("rst_s", s_out, 0);
      check("rst_r", r_out, 0);
      check("rst_done", done, 0);
    end
    bus.req_valid = 1'b0;
    load_en       = 1'b0;
    reset         = 1'b1;
    @(negedge clk);
    check("post_rst_ready", bus.req_ready, 1);
    check("post_rst_done", done, 0);
    check("post_rst_err", err, 0);

    for (int i = 0; i < 5; i++) run_txn(vecs[i]);

    // Abort during SETTLE: outputs drop asynchronously and no done follows.
    @(negedge clk);
    load_en = 1'b1; load_val = 8'h00; stuck0 = 8'h00;
    @(negedge clk);
    load_en = 1'b0;
    bus.req_data = 8'h3C; bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    check("abort_drive_s", s_out, 8'h3C);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort_s", s_out, 0);
    check("abort_r", r_out, 0);
    check("abort_ready", bus.req_ready, 0);
    check("abort_done", done, 0);
    @(negedge clk);
    reset = 1'b1;
    n = 0;
    repeat (LAT + 2) begin
      @(negedge clk);
      if (done) n++;
    end
    check("abort_no_done", n, 0);
    run_txn('{8'h3C, 8'hC3, 8'h00, 8'hC3, 8'h3C, 8'h00, 1'b0});

    // Back-to-back with req_valid held: second accepted in the cycle after done.
    @(negedge clk);
    load_en = 1'b1; load_val = 8'h00;
    @(negedge clk);
    load_en = 1'b0;
    bus.req_data = 8'h01; bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_data = 8'h80;
    n = 0;
    while (n < 2 * LAT + 1) begin
      @(negedge clk);
      n++;
      if (n == 1) check("b2b_first_s", s_out, 8'h01);
      if (n == LAT) check("b2b_first_done", done, 1);
      if (n == LAT + 1) begin
        check("b2b_ready", bus.req_ready, 1);
        check("b2b_idle_done", done, 0);
      end
      if (n == LAT + 2) begin
        check("b2b_second_s", s_out, 8'h80);
        check("b2b_second_r", r_out, 8'h01);
        check("b2b_busy", bus.req_ready, 0);
        bus.req_valid = 1'b0;
      end
    end
    check("b2b_second_done", done, 1);
    @(negedge clk);
    check("b2b_err", err, 0);
    check("b2b_bank", q_in, 8'h80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
